// File: rtl/scan_iterator.sv
// Iteration controller closing the Scanner feedback loop: drives the working grid, remaps the
// box-ordered result back to [x][y] order and writes it back. Optional macro: SCAN_MONOTONIC_EN.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | after reset, waiting for i_Start
// S_SETTLE  | Scanner sees the new o_Grid; settle counter running down
// S_CAPTURE | sample remapped Scanner result, decide write-back / finish
// S_DONE    | result flags valid, waiting for next i_Start
module scan_iterator #(
  parameter int MAX_ITER      = 64,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                            i_Clk,
  input  logic                            i_Rst_n,
  input  logic                            i_Start,
  input  logic [8:0][8:0][8:0]            i_Load_Grid,
  output logic [8:0][8:0][8:0]            o_Grid,
  input  logic [2:0][2:0][8:0][8:0]       i_Scan_Grid,
  input  logic                            i_Scan_Complete,
  output logic                            o_Busy,
  output logic                            o_Done,
  output logic                            o_Solved,
  output logic                            o_Stalled,
  output logic                            o_Error,
  output logic [$clog2(MAX_ITER+1)-1:0]   o_Iter
);

  localparam int IW = $clog2(MAX_ITER + 1);
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
  localparam logic [IW-1:0] ITER_MAX    = IW'(MAX_ITER);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETTLE  = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t                 r_State;
  logic [SW-1:0]          r_Settle_Cnt;
  logic [8:0][8:0][8:0]   r_Grid;
  logic [IW-1:0]          r_Iter;
  logic                   r_Busy;
  logic                   r_Done;
  logic                   r_Solved;
  logic                   r_Stalled;
  logic                   r_Error;

  logic [8:0][8:0][8:0]   w_Remap;
  logic [8:0][8:0][8:0]   w_Next;
  logic                   w_Has_Zero;
  logic                   w_Unchanged;
  logic [IW-1:0]          w_Iter_Inc;

  // Box cell k of (bx,by) is column 3*bx + k%3, row 3*by + k/3.
  always_comb begin
    w_Remap = '0;
    for (int x = 0; x < 9; x++) begin
      for (int y = 0; y < 9; y++) begin
        w_Remap[x][y] = i_Scan_Grid[x/3][y/3][3*(y%3) + (x%3)];
      end
    end
  end

`ifdef SCAN_MONOTONIC_EN
  assign w_Next = w_Remap & r_Grid;
`else
  assign w_Next = w_Remap;
`endif

  always_comb begin
    w_Has_Zero = 1'b0;
    for (int x = 0; x < 9; x++) begin
      for (int y = 0; y < 9; y++) begin
        if (w_Next[x][y] == 9'h000) w_Has_Zero = 1'b1;
      end
    end
  end

  assign w_Unchanged = (w_Next == r_Grid);
  assign w_Iter_Inc  = (r_Iter == ITER_MAX) ? r_Iter : r_Iter + 1'b1;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_State      <= S_IDLE;
      r_Settle_Cnt <= '0;
      r_Grid       <= '0;
      r_Iter       <= '0;
      r_Busy       <= 1'b0;
      r_Done       <= 1'b0;
      r_Solved     <= 1'b0;
      r_Stalled    <= 1'b0;
      r_Error      <= 1'b0;
    end else begin
      case (r_State)
        S_IDLE, S_DONE: begin
          if (i_Start) begin
            r_Grid       <= i_Load_Grid;
            r_Iter       <= '0;
            r_Busy       <= 1'b1;
            r_Done       <= 1'b0;
            r_Solved     <= 1'b0;
            r_Stalled    <= 1'b0;
            r_Error      <= 1'b0;
            r_Settle_Cnt <= SETTLE_LOAD;
            r_State      <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (r_Settle_Cnt == '0) begin
            r_State <= S_CAPTURE;
          end else begin
            r_Settle_Cnt <= r_Settle_Cnt - 1'b1;
          end
        end
        S_CAPTURE: begin
          if (w_Has_Zero) begin
            r_Error <= 1'b1;
            r_Done  <= 1'b1;
            r_Busy  <= 1'b0;
            r_State <= S_DONE;
          end else if (i_Scan_Complete) begin
            r_Grid   <= w_Next;
            r_Solved <= 1'b1;
            r_Done   <= 1'b1;
            r_Busy   <= 1'b0;
            r_State  <= S_DONE;
          end else if (w_Unchanged) begin
            r_Stalled <= 1'b1;
            r_Done    <= 1'b1;
            r_Busy    <= 1'b0;
            r_State   <= S_DONE;
          end else begin
            r_Grid <= w_Next;
            r_Iter <= w_Iter_Inc;
            if (w_Iter_Inc == ITER_MAX) begin
              r_Stalled <= 1'b1;
              r_Done    <= 1'b1;
              r_Busy    <= 1'b0;
              r_State   <= S_DONE;
            end else begin
              r_Settle_Cnt <= SETTLE_LOAD;
              r_State      <= S_SETTLE;
            end
          end
        end
        default: r_State <= S_IDLE;
      endcase
    end
  end

  assign o_Grid    = r_Grid;
  assign o_Iter    = r_Iter;
  assign o_Busy    = r_Busy;
  assign o_Done    = r_Done;
  assign o_Solved  = r_Solved;
  assign o_Stalled = r_Stalled;
  assign o_Error   = r_Error;

endmodule

// File: tb/tb_scan_iterator.sv
// Directed bench for scan_iterator: two instances (default limits and MAX_ITER=3) each driven
// by a small behavioural Scanner model selected per step.
module tb_scan_iterator;

  typedef logic [8:0][8:0][8:0]      grid_t;
  typedef logic [2:0][2:0][8:0][8:0] box_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic  rst_n, start_a, start_b;
  grid_t load, grid_a, grid_b;
  box_t  scan_a, scan_b;
  logic  comp_a, comp_b;
  logic  busy_a, done_a, solved_a, stalled_a, err_a;
  logic  busy_b, done_b, solved_b, stalled_b, err_b;
  logic [6:0] iter_a;
  logic [1:0] iter_b;
  int    mode_a, mode_b;
  int    errors, checks;

  // Scanner model modes: 0 identity, 1 drop lowest candidate of first unsolved cell,
  // 2 kill grid[7][4], 3 rotate grid[0][0] left, 4 identity (complete when solved)
  function automatic box_t boxify(input grid_t g);
    box_t b;
    for (int bx = 0; bx < 3; bx++)
      for (int by = 0; by < 3; by++)
        for (int k = 0; k < 9; k++)
          b[bx][by][k] = g[3*bx + k%3][3*by + k/3];
    return b;
  endfunction

  function automatic grid_t scanner_next(input int mode, input grid_t g);
    grid_t n;
    bit    found;
    n = g;
    found = 0;
    case (mode)
      1: for (int x = 0; x < 9; x++)
           for (int y = 0; y < 9; y++)
             if (!found && $countones(n[x][y]) > 1) begin
               n[x][y] = n[x][y] & (n[x][y] - 9'd1);
               found = 1;
             end
      2: n[7][4] = 9'h000;
      3: n[0][0] = {g[0][0][7:0], g[0][0][8]};
      default: ;
    endcase
    return n;
  endfunction

  function automatic logic all_onehot(input grid_t g);
    logic ok;
    ok = 1'b1;
    for (int x = 0; x < 9; x++)
      for (int y = 0; y < 9; y++)
        if ($countones(g[x][y]) != 1) ok = 1'b0;
    return ok;
  endfunction

  assign scan_a = boxify(scanner_next(mode_a, grid_a));
  assign scan_b = boxify(scanner_next(mode_b, grid_b));
  assign comp_a = (mode_a == 1 || mode_a == 4) && all_onehot(grid_a);
  assign comp_b = (mode_b == 1 || mode_b == 4) && all_onehot(grid_b);

  scan_iterator #(.MAX_ITER(64), .SETTLE_CYCLES(2)) u_dut_a (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Start(start_a), .i_Load_Grid(load),
    .o_Grid(grid_a), .i_Scan_Grid(scan_a), .i_Scan_Complete(comp_a),
    .o_Busy(busy_a), .o_Done(done_a), .o_Solved(solved_a), .o_Stalled(stalled_a),
    .o_Error(err_a), .o_Iter(iter_a)
  );

  scan_iterator #(.MAX_ITER(3), .SETTLE_CYCLES(2)) u_dut_b (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Start(start_b), .i_Load_Grid(load),
    .o_Grid(grid_b), .i_Scan_Grid(scan_b), .i_Scan_Complete(comp_b),
    .o_Busy(busy_b), .o_Done(done_b), .o_Solved(solved_b), .o_Stalled(stalled_b),
    .o_Error(err_b), .o_Iter(iter_b)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [728:0] obs, input logic [728:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_a();
    start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
  endtask

  task automatic pulse_b();
    start_b = 1'b1;
    tick(1);
    start_b = 1'b0;
  endtask

  task automatic wait_done_a(output int n);
    n = 0;
    while (!done_a && n < 200) begin
      tick(1);
      n++;
    end
    chk("done_a_timeout", done_a, 1'b1);
  endtask

  grid_t solved_g, distinct_g, multi_g, exp_g;
  int    cyc;

  initial begin
    errors = 0; checks = 0;
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
    load = '0; mode_a = 0; mode_b = 3;
    for (int x = 0; x < 9; x++)
      for (int y = 0; y < 9; y++) begin
        solved_g[x][y]   = 9'(1 << ((x + 3*y + y/3) % 9));
        distinct_g[x][y] = 9'((x*9 + y)*5 + 1);
      end
    multi_g = solved_g;
    multi_g[0][0] = 9'h003;
    multi_g[1][0] = 9'h00F;
    multi_g[2][0] = 9'h006;

    tick(2);
    chk("rst_grid",  grid_a, '0);
    chk("rst_busy",  busy_a, 1'b0);
    chk("rst_done",  done_a, 1'b0);
    chk("rst_flags", {solved_a, stalled_a, err_a}, 3'b000);
    chk("rst_iter",  iter_a, 7'd0);
    rst_n = 1'b1;
    tick(1);

    // solved on load: done exactly SETTLE_CYCLES+1 edges after the start edge
    mode_a = 4; load = solved_g;
    pulse_a();
    chk("load_grid", grid_a, solved_g);
    chk("load_busy", busy_a, 1'b1);
    tick(2);
    chk("sol_early_done", done_a, 1'b0);
    chk("sol_early_busy", busy_a, 1'b1);
    tick(1);
    chk("sol_done",   done_a, 1'b1);
    chk("sol_busy",   busy_a, 1'b0);
    chk("sol_flags",  {solved_a, stalled_a, err_a}, 3'b100);
    chk("sol_iter",   iter_a, 7'd0);

    // five candidate removals, then complete
    mode_a = 1; load = multi_g;
    pulse_a();
    chk("multi_done_clr", done_a, 1'b0);
    wait_done_a(cyc);
    chk("multi_cycles", cyc, 18);
    chk("multi_flags",  {solved_a, stalled_a, err_a}, 3'b100);
    chk("multi_iter",   iter_a, 7'd5);
    exp_g = solved_g;
    exp_g[0][0] = 9'h002;
    exp_g[1][0] = 9'h008;
    exp_g[2][0] = 9'h004;
    chk("multi_grid",   grid_a, exp_g);

    // identity Scanner on an unsolved grid: stall with no write-back
    mode_a = 0; load = distinct_g;
    pulse_a();
    wait_done_a(cyc);
    chk("stall_cycles", cyc, 3);
    chk("stall_flags",  {solved_a, stalled_a, err_a}, 3'b010);
    chk("stall_iter",   iter_a, 7'd0);
    chk("stall_grid",   grid_a, distinct_g);

    // empty mask at box (2,1) k=4 -> grid[7][4]
    mode_a = 2; load = distinct_g;
    pulse_a();
    wait_done_a(cyc);
    chk("err_flags", {solved_a, stalled_a, err_a}, 3'b001);
    chk("err_iter",  iter_a, 7'd0);
    chk("err_grid",  grid_a, distinct_g);

    // iteration limit with a mid-run start that must be ignored
    mode_b = 3; load = solved_g;
    pulse_b();
    tick(4);
    load = '1;
    start_b = 1'b1;
    tick(1);
    start_b = 1'b0;
    load = solved_g;
    tick(3);
    chk("lim_early_done", done_b, 1'b0);
    chk("lim_early_busy", busy_b, 1'b1);
    chk("lim_early_iter", iter_b, 2'd2);
    tick(1);
    chk("lim_done",  done_b, 1'b1);
    chk("lim_flags", {solved_b, stalled_b, err_b}, 3'b010);
    chk("lim_iter",  iter_b, 2'd3);
    exp_g = solved_g;
    exp_g[0][0] = 9'h008;
    chk("lim_grid",  grid_b, exp_g);

    // asynchronous reset in SETTLE, then clean restart
    mode_a = 0; load = distinct_g;
    pulse_a();
    tick(1);
    rst_n = 1'b0;
    #1;
    chk("arst_grid", grid_a, '0);
    chk("arst_busy_done", {busy_a, done_a}, 2'b00);
    chk("arst_flags", {solved_a, stalled_a, err_a}, 3'b000);
    chk("arst_iter", iter_a, 7'd0);
    tick(1);
    rst_n = 1'b1;
    tick(1);
    mode_a = 4; load = solved_g;
    pulse_a();
    chk("rs_iter_start", iter_a, 7'd0);
    tick(3);
    chk("rs_done",  done_a, 1'b1);
    chk("rs_flags", {solved_a, stalled_a, err_a}, 3'b100);
    chk("rs_iter",  iter_a, 7'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/scan_iterator.md
# scan_iterator

Iteration controller that sits directly downstream of the Scanner and closes its feedback loop. It holds the working 9x9 candidate-mask grid, drives it into the Scanner, waits for the Scanner's registered result, remaps the box-ordered result back into column/row order, and writes it back. It repeats until the puzzle is solved, no further progress is made, a contradiction appears, or an iteration limit is reached.

## Interface
Parameters:
- MAX_ITER, 64: maximum write-back iterations before giving up; must be ≥1.
- SETTLE_CYCLES, 2: cycles to wait after each grid update before sampling Scanner outputs; must be ≥1.

Ports (clock and reset first):
- i_Clk  in  1  single clock for the block.
- i_Rst_n  in  1  asynchronous, active-low reset.
- i_Start  in  1  single-cycle pulse; loads i_Load_Grid and begins solving.
- i_Load_Grid  in  [8:0] x [8:0][8:0]  initial candidate masks, indexed [x][y] (x = column 0..8, y = row 0..8); bit d-1 set means digit d is possible.
- o_Grid  out  [8:0] x [8:0][8:0]  registered working grid, same indexing as i_Load_Grid; connects to Scanner i_Grid.
- i_Scan_Grid  in  [8:0] x [2:0][2:0][8:0]  Scanner o_Grid, indexed [bx][by][k].
- i_Scan_Complete  in  1  Scanner o_Complete.
- o_Busy  out  1  high from the cycle after i_Start until the cycle DONE is entered.
- o_Done  out  1  level; high in DONE until the next accepted i_Start.
- o_Solved, o_Stalled, o_Error  out  1 each  result flags, valid while o_Done is high, mutually exclusive.
- o_Iter  out  $clog2(MAX_ITER+1)  number of write-backs performed.

## Operation
- Remap: box cell k of (bx,by) corresponds to grid[3*bx + k%3][3*by + k/3], for k = 0..8 (k = 3*local_row + local_col).
- States: IDLE, SETTLE, CAPTURE, DONE.
- IDLE and DONE: i_Start=1 loads o_Grid <= i_Load_Grid, clears o_Iter and all flags, deasserts o_Done, and enters SETTLE. In all other states i_Start is ignored.
- SETTLE: the settle counter counts SETTLE_CYCLES cycles, then the block enters CAPTURE.
- CAPTURE, single cycle. N is the remapped grid. Checks are applied in this priority order:
  1. Any cell of N == 9'h000: o_Error=1, go to DONE; o_Grid is not written.
  2. i_Scan_Complete=1: o_Grid <= N, o_Solved=1, go to DONE.
  3. N == o_Grid: o_Stalled=1, go to DONE.
  4. Otherwise: o_Grid <= N and o_Iter++. If the new o_Iter == MAX_ITER, set o_Stalled=1 and go to DONE; otherwise go to SETTLE.
- o_Iter saturates at MAX_ITER and never wraps.
- Reset (asynchronous, at any point, including mid-iteration): state=IDLE, o_Grid all 9'h000, o_Iter=0, and every output flag 0.

## Timing
- i_Start sampled at edge T: o_Grid holds the loaded value after T, and o_Busy=1 after T.
- CAPTURE occurs SETTLE_CYCLES+1 edges after each o_Grid update.
- One iteration takes SETTLE_CYCLES+1 cycles.
- The flags and o_Done update at the same edge that leaves CAPTURE for DONE. o_Busy falls at that same edge.
- A solved-on-load puzzle completes in SETTLE_CYCLES+1 cycles with o_Iter=0.

## Configuration
- SCAN_MONOTONIC_EN defined: the write-back value is N & o_Grid, so candidates can only be removed. The equality test and the zero-mask test in CAPTURE both use this ANDed value.
- SCAN_MONOTONIC_EN undefined: N is written back unmodified.

## Test plan
- Solved grid loaded (every cell one-hot), i_Scan_Complete=1 -> o_Done=1, o_Solved=1, o_Iter=0 after SETTLE_CYCLES+1 cycles.
- Scanner model clears one candidate per pass for 5 passes, then asserts complete -> o_Solved=1, o_Iter=5, o_Grid equals the final remapped grid.
- Scanner returns its input unchanged, with the puzzle unsolved -> o_Stalled=1, o_Iter=0, o_Grid unchanged.
- Scanner returns 9'h000 at box (2,1) k=4, i.e. grid[7][4] -> o_Error=1, o_Grid not updated, o_Solved=0.
- MAX_ITER=3, Scanner always changes the grid and never completes -> o_Stalled=1, o_Iter=3. i_Start pulsed mid-run is ignored.
- i_Rst_n low for 1 cycle during SETTLE -> all outputs 0 immediately. After release, i_Start restarts cleanly with o_Iter=0.
